// File: rtl/final_pkg.sv
// Shared types and constants for the intersection traffic-light controller:
// phase encoding, lamp patterns and counter-input select codes.
package final_pkg;

    typedef enum logic [2:0] {
        ST_INIT = 3'd0,
        ST_NS_G = 3'd1,
        ST_NS_Y = 3'd2,
        ST_AR1  = 3'd3,
        ST_EW_G = 3'd4,
        ST_EW_Y = 3'd5,
        ST_AR2  = 3'd6
    } state_e;

    // Lamp pattern bit order: {NR, NG, NY, ER, EG, EY}
    localparam logic [5:0] LAMP_ALL_RED = 6'b100100;
    localparam logic [5:0] LAMP_NS_G    = 6'b010100;
    localparam logic [5:0] LAMP_NS_Y    = 6'b001100;
    localparam logic [5:0] LAMP_EW_G    = 6'b100010;
    localparam logic [5:0] LAMP_EW_Y    = 6'b100001;
    localparam logic [5:0] LAMP_DARK    = 6'b000000;

    localparam logic [1:0] IC_ONE = 2'b00;
    localparam logic [1:0] IC_R   = 2'b01;
    localparam logic [1:0] IC_NLC = 2'b10;
    localparam logic [1:0] IC_LNC = 2'b11;

    function automatic logic [5:0] lamp_pattern(input state_e st);
        logic [5:0] pat;
        case (st)
            ST_INIT: pat = LAMP_ALL_RED;
            ST_NS_G: pat = LAMP_NS_G;
            ST_NS_Y: pat = LAMP_NS_Y;
            ST_AR1:  pat = LAMP_ALL_RED;
            ST_EW_G: pat = LAMP_EW_G;
            ST_EW_Y: pat = LAMP_EW_Y;
            ST_AR2:  pat = LAMP_ALL_RED;
            default: pat = LAMP_DARK;
        endcase
        return pat;
    endfunction

    function automatic logic [1:0] ic_code(input state_e st);
        logic [1:0] code;
        case (st)
            ST_NS_G: code = IC_NLC;
            ST_EW_G: code = IC_LNC;
            ST_NS_Y: code = IC_R;
            ST_EW_Y: code = IC_R;
            default: code = IC_ONE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/final_controller_dwell_timer.sv
// Saturating dwell counter: clear wins over advance, and the count freezes
// whenever advance is low.
module dwell_timer #(
    parameter int TW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [TW-1:0] count
);

    localparam logic [TW-1:0] CNT_MAX  = {TW{1'b1}};
    localparam logic [TW-1:0] CNT_ZERO = {TW{1'b0}};
    localparam logic [TW-1:0] CNT_ONE  = {{(TW-1){1'b0}}, 1'b1};

    logic [TW-1:0] count_q;
    logic [TW-1:0] count_d;

    // Next count: clear, saturating increment or hold
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = CNT_ZERO;
        end else if (inc && (count_q != CNT_MAX)) begin
            count_d = count_q + CNT_ONE;
        end else begin
            count_d = count_q;
        end
    end

    // Count register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= CNT_ZERO;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/final_controller.sv
// Phase sequencer for the N/E intersection: drives lamp select/enable pulses
// on phase entry and the counter-input select for the datapath.
module final_controller
    import final_pkg::*;
#(
    parameter int TW       = 8,
    parameter int T_AR     = 2,
    parameter int T_YEL    = 3,
    parameter int T_NS_MIN = 5,
    parameter int T_EW_MIN = 4,
    parameter int T_EW_MAX = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       not_r,
    input  logic       c_and_l,
    input  logic       en_s,
    input  logic       l_or_notc,
    output logic       s_NR,
    output logic       s_NG,
    output logic       s_NY,
    output logic       s_ER,
    output logic       s_EG,
    output logic       s_EY,
    output logic       en_NR,
    output logic       en_NG,
    output logic       en_NY,
    output logic       en_ER,
    output logic       en_EG,
    output logic       en_EY,
    output logic [1:0] s_IC,
    output logic       en_IC
);

    localparam logic [TW-1:0] AR_LAST     = TW'(T_AR - 1);
    localparam logic [TW-1:0] YEL_LAST    = TW'(T_YEL - 1);
    localparam logic [TW-1:0] NS_MIN_LAST = TW'(T_NS_MIN - 1);
    localparam logic [TW-1:0] EW_MIN_LAST = TW'(T_EW_MIN - 1);
    localparam logic [TW-1:0] EW_MAX_LAST = TW'(T_EW_MAX - 1);

    state_e        state_q;
    state_e        state_d;
    logic          entry_q;
    logic          entry_d;
    logic          tmr_clr_s;
    logic          tmr_inc_s;
    logic          leave_s;
    state_e        next_st_s;
    logic [TW-1:0] timer_s;
    logic          active_s;
    logic          pulse_s;
    logic [5:0]    lamps_s;
    logic [1:0]    ic_s;

    dwell_timer #(
        .TW (TW)
    ) u_dwell_timer (
        .clk   (clk),
        .rst   (rst),
        .clr   (tmr_clr_s),
        .inc   (tmr_inc_s),
        .count (timer_s)
    );

    // Phase exit condition and successor for the current state
    always_comb begin
        leave_s   = 1'b0;
        next_st_s = ST_INIT;
        case (state_q)
            ST_INIT: begin
                leave_s   = (timer_s == AR_LAST);
                next_st_s = ST_NS_G;
            end
            ST_NS_G: begin
                leave_s   = (timer_s >= NS_MIN_LAST) && c_and_l;
                next_st_s = ST_NS_Y;
            end
            ST_NS_Y: begin
                leave_s   = (timer_s == YEL_LAST);
                next_st_s = ST_AR1;
            end
            ST_AR1: begin
                leave_s   = (timer_s == AR_LAST);
                next_st_s = ST_EW_G;
            end
            ST_EW_G: begin
                leave_s   = ((timer_s >= EW_MIN_LAST) && l_or_notc) ||
                            (timer_s == EW_MAX_LAST);
                next_st_s = ST_EW_Y;
            end
            ST_EW_Y: begin
                leave_s   = (timer_s == YEL_LAST);
                next_st_s = ST_AR2;
            end
            ST_AR2: begin
                leave_s   = (timer_s == AR_LAST);
                next_st_s = ST_NS_G;
            end
            default: begin
                leave_s   = 1'b1;
                next_st_s = ST_INIT;
            end
        endcase
    end

    // Next state, entry flag and timer control with abort/hold priority
    always_comb begin
        state_d   = state_q;
        entry_d   = entry_q;
        tmr_clr_s = 1'b0;
        tmr_inc_s = 1'b0;
        if (not_r) begin
            tmr_clr_s = 1'b1;
            if (state_q == ST_INIT) begin
                // Already all-red: no fresh pulse, but a held one survives
                entry_d = en_s ? 1'b0 : entry_q;
            end else begin
                state_d = ST_INIT;
                entry_d = 1'b1;
            end
        end else if (!en_s) begin
            state_d = state_q;
            entry_d = entry_q;
        end else if (leave_s) begin
            state_d   = next_st_s;
            entry_d   = 1'b1;
            tmr_clr_s = 1'b1;
        end else begin
            entry_d   = 1'b0;
            tmr_inc_s = 1'b1;
        end
    end

    // State and entry-flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
            entry_q <= 1'b1;
        end else begin
            state_q <= state_d;
            entry_q <= entry_d;
        end
    end

    // Output decode from registered state, gated by reset and hold
    always_comb begin
        active_s = en_s && !rst;
        pulse_s  = active_s && entry_q;
        if (pulse_s) begin
            lamps_s = lamp_pattern(state_q);
        end else begin
            lamps_s = LAMP_DARK;
        end
        if (active_s) begin
            ic_s = ic_code(state_q);
        end else begin
            ic_s = IC_ONE;
        end
    end

    assign {s_NR, s_NG, s_NY, s_ER, s_EG, s_EY} = lamps_s;
    assign {en_NR, en_NG, en_NY, en_ER, en_EG, en_EY} = {6{pulse_s}};
    assign s_IC  = ic_s;
    assign en_IC = active_s;

endmodule

// File: tb/tb_final_controller.sv
// Directed bench for final_controller: a phase/age reference model checked
// every cycle, plus literal expectations at hand-picked cycles.
module tb_final_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       not_r = 1'b0;
    logic       c_and_l = 1'b0;
    logic       en_s = 1'b1;
    logic       l_or_notc = 1'b0;
    logic       s_NR, s_NG, s_NY, s_ER, s_EG, s_EY;
    logic       en_NR, en_NG, en_NY, en_ER, en_EG, en_EY;
    logic [1:0] s_IC;
    logic       en_IC;

    int errors = 0;
    int checks = 0;
    int cyc = -1;

    final_controller dut (
        .clk(clk), .rst(rst), .not_r(not_r), .c_and_l(c_and_l), .en_s(en_s),
        .l_or_notc(l_or_notc),
        .s_NR(s_NR), .s_NG(s_NG), .s_NY(s_NY), .s_ER(s_ER), .s_EG(s_EG), .s_EY(s_EY),
        .en_NR(en_NR), .en_NG(en_NG), .en_NY(en_NY), .en_ER(en_ER), .en_EG(en_EG),
        .en_EY(en_EY), .s_IC(s_IC), .en_IC(en_IC)
    );

    always #5 clk = ~clk;

    logic [14:0] act_vec;
    assign act_vec = {s_NR, s_NG, s_NY, s_ER, s_EG, s_EY,
                      en_NR, en_NG, en_NY, en_ER, en_EG, en_EY, s_IC, en_IC};

    // Reference model: phase 0..6 = INIT, NS_G, NS_Y, AR1, EW_G, EW_Y, AR2
    logic [5:0]  pat [0:6] = '{6'b100100, 6'b010100, 6'b001100, 6'b100100,
                              6'b100010, 6'b100001, 6'b100100};
    logic [1:0]  ic  [0:6] = '{2'b00, 2'b10, 2'b01, 2'b00, 2'b11, 2'b01, 2'b00};
    logic [14:0] exp_vec = 15'd0;
    int          ph = 0;
    int          age = 0;
    bit          fresh = 1'b1;
    bit          mvalid = 1'b0;

    always @(negedge clk) begin
        bit leave;
        #2;
        if (rst || !en_s) begin
            exp_vec = 15'd0;
        end else begin
            exp_vec = {fresh ? pat[ph] : 6'b000000, fresh ? 6'b111111 : 6'b000000,
                       ic[ph], 1'b1};
        end
        if (rst || mvalid) begin
            checks++;
            if (act_vec !== exp_vec) begin
                errors++;
                $display("FAIL model_cmp cycle=%0d got=%b want=%b", cyc, act_vec, exp_vec);
            end
        end
        if (rst) begin
            ph = 0; age = 0; fresh = 1'b1; mvalid = 1'b1;
        end else if (not_r) begin
            if (ph == 0) begin
                age = 0;
                fresh = en_s ? 1'b0 : fresh;
            end else begin
                ph = 0; age = 0; fresh = 1'b1;
            end
        end else if (en_s) begin
            case (ph)
                1:       leave = (age >= 4) && c_and_l;
                2, 5:    leave = (age == 2);
                4:       leave = ((age >= 3) && l_or_notc) || (age == 9);
                default: leave = (age == 1);
            endcase
            if (leave) begin
                ph = (ph == 6) ? 1 : ph + 1;
                age = 0;
                fresh = 1'b1;
            end else begin
                age++;
                fresh = 1'b0;
            end
        end
    end

    task automatic chk_lit(input string name, input logic [14:0] want);
        checks++;
        if (act_vec !== want) begin
            errors++;
            $display("FAIL %s cycle=%0d dut=%b want=%b", name, cyc, act_vec, want);
        end
        checks++;
        if (exp_vec !== want) begin
            errors++;
            $display("FAIL %s_model cycle=%0d model=%b want=%b", name, cyc, exp_vec, want);
        end
    endtask

    localparam logic [14:0] V_AR_ENT  = 15'b100100_111111_00_1;
    localparam logic [14:0] V_NSG_ENT = 15'b010100_111111_10_1;
    localparam logic [14:0] V_NSY_ENT = 15'b001100_111111_01_1;
    localparam logic [14:0] V_EWG_ENT = 15'b100010_111111_11_1;
    localparam logic [14:0] V_EWY_ENT = 15'b100001_111111_01_1;
    localparam logic [14:0] V_AR_IDL  = 15'b000000_000000_00_1;
    localparam logic [14:0] V_NSG_IDL = 15'b000000_000000_10_1;
    localparam logic [14:0] V_NSY_IDL = 15'b000000_000000_01_1;
    localparam logic [14:0] V_EWG_IDL = 15'b000000_000000_11_1;
    localparam logic [14:0] V_ZERO    = 15'd0;

    initial begin
        for (int r = 0; r < 3; r++) begin
            @(negedge clk);
            rst = 1'b1;
            #3 chk_lit("reset", V_ZERO);
        end
        for (int n = 0; n <= 75; n++) begin
            @(negedge clk);
            cyc       = n;
            rst       = (n == 67);
            not_r     = (n == 62) || (n == 69);
            en_s      = !(n >= 33 && n <= 36);
            c_and_l   = (n >= 3 && n < 7) || (n >= 27 && n < 32) || (n >= 50 && n < 55);
            l_or_notc = (n >= 41 && n < 45);
            #3;
            case (n)
                0, 63, 68:       chk_lit("init_entry", V_AR_ENT);
                1, 70:           chk_lit("init_idle", V_AR_IDL);
                2, 27, 65, 72:   chk_lit("nsg_entry", V_NSG_ENT);
                6:               chk_lit("nsg_min_wait", V_NSG_IDL);
                7, 32:           chk_lit("nsy_entry", V_NSY_ENT);
                10, 25, 39:      chk_lit("allred_entry", V_AR_ENT);
                12, 41:          chk_lit("ewg_entry", V_EWG_ENT);
                21, 44:          chk_lit("ewg_last", V_EWG_IDL);
                22, 45:          chk_lit("ewy_entry", V_EWY_ENT);
                33, 34, 35, 36:  chk_lit("hold", V_ZERO);
                38:              chk_lit("nsy_resume", V_NSY_IDL);
                67:              chk_lit("mid_reset", V_ZERO);
                default:         ;
            endcase
        end
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
